// File: rtl/aes_256_arbiter.sv
// Two-requester round-robin front end for a shared AES-256 core.
// Per job: capture operands, clear the core, run it, then return a result or a timeout abort.
module aes_256_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [127:0] data_in0,
    input  logic [127:0] data_in1,
    input  logic [255:0] cipher_key0,
    input  logic [255:0] cipher_key1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         vld0,
    output logic         vld1,
    output logic         err0,
    output logic         err1,
    output logic [127:0] data_out,
    output logic         busy,
    output logic [127:0] core_data_in,
    output logic [255:0] core_key,
    output logic         core_en,
    output logic         core_rst_n,
    input  logic [127:0] core_data_out,
    input  logic         core_done
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        RUN,
        DONE,
        ABORT
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic       owner;
    logic       last_owner;
    logic       pick;
    logic [7:0] cnt;

    // On contention, the requester that was not served last wins.
    always_comb begin
        if (req0 && req1) pick = ~last_owner;
        else              pick = req1;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req0 || req1) state_nxt = CLR;
            CLR:     state_nxt = RUN;
            RUN: begin
                if (core_done)             state_nxt = DONE;
                else if (cnt == CNT_LAST)  state_nxt = ABORT;
            end
            DONE:    state_nxt = IDLE;
            ABORT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gating on Rst keeps every strobe low and the core held in reset
    // for as long as reset is applied, not only after the first edge.
    always_comb begin
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        vld0       = 1'b0;
        vld1       = 1'b0;
        err0       = 1'b0;
        err1       = 1'b0;
        busy       = 1'b0;
        core_en    = 1'b0;
        core_rst_n = 1'b0;
        if (Rst) begin
            unique case (state)
                IDLE: core_rst_n = 1'b1;
                CLR: begin
                    gnt0 = ~owner;
                    gnt1 = owner;
                    busy = 1'b1;
                end
                RUN: begin
                    core_en    = 1'b1;
                    core_rst_n = 1'b1;
                    busy       = 1'b1;
                end
                DONE: begin
                    vld0       = ~owner;
                    vld1       = owner;
                    core_rst_n = 1'b1;
                    busy       = 1'b1;
                end
                ABORT: begin
                    err0 = ~owner;
                    err1 = owner;
                    busy = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            owner        <= 1'b0;
            last_owner   <= 1'b1;
            data_out     <= 128'd0;
            core_data_in <= 128'd0;
            core_key     <= 256'd0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner        <= pick;
                        core_data_in <= pick ? data_in1 : data_in0;
                        core_key     <= pick ? cipher_key1 : cipher_key0;
                    end
                end
                CLR: cnt <= 8'd0;
                RUN: begin
                    cnt <= cnt + 8'd1;
                    if (core_done) data_out <= core_data_out;
                end
                DONE:    last_owner <= owner;
                ABORT:   last_owner <= owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_256_arbiter.sv
// Directed bench for aes_256_arbiter with a stub AES core
// whose result is data XOR key[127:0] after a programmable delay.
module tb_aes_256_arbiter;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic [127:0] data_in0 = '0;
    logic [127:0] data_in1 = '0;
    logic [255:0] cipher_key0 = '0;
    logic [255:0] cipher_key1 = '0;
    logic         gnt0, gnt1, vld0, vld1, err0, err1;
    logic [127:0] data_out;
    logic         busy;
    logic [127:0] core_data_in;
    logic [255:0] core_key;
    logic         core_en;
    logic         core_rst_n;
    logic [127:0] core_data_out;
    logic         core_done;

    localparam logic [127:0] D0 = 128'h2a179373117e3de9969f402ee2bec16b;
    localparam logic [255:0] K0 =
        256'hf4df1409a310982dd708613b072c351f81777d85f0ae732bbe71ca1510eb3d60;
    localparam logic [127:0] E0 = 128'hab60eef6e1d04ec228ee8a3bf255fc0b;
    localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K1 = {128'h0, 128'hffffffffffffffff0000000000000000};
    localparam logic [127:0] E1 = 128'hffeeddccbbaa99888899aabbccddeeff;

    int n_vec = 0;
    int n_bad = 0;
    int n_multi = 0;

    // Stub core: done fires when the enabled-cycle count hits done_at.
    int   stub_cnt;
    int   done_at = 14;
    logic done_en = 1'b1;

    always_ff @(posedge Clk) begin
        if (!core_rst_n)  stub_cnt <= 0;
        else if (core_en) stub_cnt <= stub_cnt + 1;
    end

    assign core_done     = done_en && core_en && (stub_cnt == done_at);
    assign core_data_out = core_data_in ^ core_key[127:0];

    always #5 Clk = ~Clk;

    aes_256_arbiter #(.TIMEOUT_CYCLES(64)) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .req0         (req0),
        .req1         (req1),
        .data_in0     (data_in0),
        .data_in1     (data_in1),
        .cipher_key0  (cipher_key0),
        .cipher_key1  (cipher_key1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .vld0         (vld0),
        .vld1         (vld1),
        .err0         (err0),
        .err1         (err1),
        .data_out     (data_out),
        .busy         (busy),
        .core_data_in (core_data_in),
        .core_key     (core_key),
        .core_en      (core_en),
        .core_rst_n   (core_rst_n),
        .core_data_out(core_data_out),
        .core_done    (core_done)
    );

    always @(negedge Clk) begin
        if (Rst && $countones({gnt0, gnt1, vld0, vld1, err0, err1}) > 1)
            n_multi++;
    end

    task automatic check(input string tag,
                         input logic [255:0] obs,
                         input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Runs until a vld/err strobe is visible; n = edges taken.
    task automatic run_job(output int n,
                           output logic [1:0] v,
                           output logic [1:0] e);
        n = 0;
        v = 2'b00;
        e = 2'b00;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (vld0 || vld1 || err0 || err1) begin
                n = i;
                v = {vld1, vld0};
                e = {err1, err0};
                break;
            end
        end
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        tick();
        tick();
        Rst = 1'b1;
        #1;
    endtask

    int         n;
    logic [1:0] v;
    logic [1:0] e;
    logic [127:0] held;
    int         strobes;

    initial begin
        data_in0    = D0;
        cipher_key0 = K0;
        data_in1    = D1;
        cipher_key1 = K1;

        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_core_rst_n", core_rst_n, 1'b0);
        tick();
        tick();
        check("rst_data_out", data_out, 128'd0);
        check("rst_strobes", {gnt0, gnt1, vld0, vld1, err0, err1}, 6'd0);
        check("rst_core_en", core_en, 1'b0);
        Rst = 1'b1;
        #1;
        check("idle_core_rst_n", core_rst_n, 1'b1);

        // Single requester 0, 15-cycle core.
        done_at = 14;
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        check("a_gnt", {gnt1, gnt0}, 2'b01);
        check("a_clr_core_rst_n", core_rst_n, 1'b0);
        check("a_busy", busy, 1'b1);
        check("a_core_data_in", core_data_in, D0);
        check("a_core_key", core_key, K0);
        run_job(n, v, e);
        check("a_latency", n + 1, 17);
        check("a_vld", v, 2'b01);
        check("a_err", e, 2'b00);
        check("a_data_out", data_out, E0);
        check("a_done_core_en", core_en, 1'b0);
        tick();
        check("a_idle_busy", busy, 1'b0);

        // Simultaneous requests right after reset: 0 first, then 1.
        do_reset();
        done_at = 2;
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        req0 = 1'b0;
        check("b_first_gnt", {gnt1, gnt0}, 2'b01);
        run_job(n, v, e);
        check("b_first_vld", v, 2'b01);
        tick();
        check("b_idle_gnt", {gnt1, gnt0}, 2'b00);
        check("b_idle_busy", busy, 1'b0);
        tick();
        req1 = 1'b0;
        check("b_second_gnt", {gnt1, gnt0}, 2'b10);
        check("b_core_data_in", core_data_in, D1);
        run_job(n, v, e);
        check("b_second_vld", v, 2'b10);
        check("b_data_out", data_out, E1);
        tick();

        // Both held: strict alternation starting with requester 0.
        req0 = 1'b1;
        req1 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 200; i++) begin
                tick();
                if (gnt0 || gnt1) break;
            end
            check($sformatf("c_gnt%0d", j), {gnt1, gnt0},
                  (j % 2 == 0) ? 2'b01 : 2'b10);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        run_job(n, v, e);
        check("c_last_vld", v, 2'b10);
        tick();

        // Core never finishes: abort after 64 RUN cycles.
        held = data_out;
        done_en = 1'b0;
        req1 = 1'b1;
        tick();
        req1 = 1'b0;
        check("d_gnt", {gnt1, gnt0}, 2'b10);
        run_job(n, v, e);
        check("d_run_cycles", n - 1, 64);
        check("d_err", e, 2'b10);
        check("d_vld", v, 2'b00);
        check("d_abort_core_rst_n", core_rst_n, 1'b0);
        check("d_abort_core_en", core_en, 1'b0);
        check("d_data_out_held", data_out, held);
        tick();
        check("d_idle_busy", busy, 1'b0);

        // Done on the timeout cycle wins.
        done_en = 1'b1;
        done_at = 63;
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        check("e_gnt", {gnt1, gnt0}, 2'b01);
        run_job(n, v, e);
        check("e_run_cycles", n - 1, 64);
        check("e_vld", v, 2'b01);
        check("e_err", e, 2'b00);
        check("e_data_out", data_out, E0);
        tick();

        // Reset mid-RUN abandons the job silently.
        done_at = 14;
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        tick();
        tick();
        tick();
        check("f_in_run", core_en, 1'b1);
        Rst = 1'b0;
        #1;
        check("f_rst_core_rst_n", core_rst_n, 1'b0);
        tick();
        check("f_busy", busy, 1'b0);
        check("f_core_en", core_en, 1'b0);
        Rst = 1'b1;
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (vld0 || vld1 || err0 || err1) strobes++;
        end
        check("f_no_strobe", strobes, 0);
        check("f_data_out", data_out, 128'd0);

        check("one_hot_strobes", n_multi, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
